// File: rtl/bpsk_pkg.sv
// -----------------------------------------------------------------------------
// bpsk_pkg
//   Shared definitions for the BPSK symbol mapper and its saturating-negation
//   helper. It holds the default sample width and symbol length, the symbol
//   state enum, and the signed sample limits for the default width.
// -----------------------------------------------------------------------------
package bpsk_pkg;

  localparam int DEF_DATA_W          = 8;
  localparam int DEF_SAMPLES_PER_BIT = 30;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic signed [DEF_DATA_W-1:0] SAMPLE_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic signed [DEF_DATA_W-1:0] SAMPLE_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage : bpsk_pkg

// File: rtl/bpsk_neg_sat.sv
// -----------------------------------------------------------------------------
// bpsk_neg_sat
//   Combinational two's-complement negation with saturation. The most negative
//   input has no positive counterpart, so it maps to the most positive value.
//   Zero maps to zero.
//
// Ports:
//   i_sample  in   DATA_W  signed sample
//   o_sample  out  DATA_W  signed negated sample, saturated
// -----------------------------------------------------------------------------
module bpsk_neg_sat #(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] i_sample,
  output logic signed [DATA_W-1:0] o_sample
);

  localparam logic signed [DATA_W-1:0] L_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] L_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  assign o_sample = (i_sample == L_MIN) ? L_MAX : -i_sample;

endmodule : bpsk_neg_sat

// File: rtl/bpsk_symbol_mapper.sv
// -----------------------------------------------------------------------------
// bpsk_symbol_mapper
//   Modulates a free-running signed carrier with one data bit per symbol.
//   Each symbol spans one full phase-counter period (cnt = 0..SAMPLES_PER_BIT-1).
//   A bit of 1 passes the carrier unchanged, a bit of 0 passes it negated.
//   Bits arrive over valid/ready into a one-entry holding register. At the
//   last phase of each period the holding register (or a bypassed input bit)
//   becomes the current symbol.
//
// Ports:
//   Clk         in   1       system clock, one carrier sample per edge
//   Rst_n       in   1       synchronous active-low reset
//   carrier_in  in   DATA_W  signed carrier sample
//   bit_in      in   1       data bit to modulate
//   bit_valid   in   1       bit_in is valid
//   bit_ready   out  1       a bit can be accepted this cycle
//   data_out    out  DATA_W  registered modulated sample
//   out_valid   out  1       data_out belongs to an active symbol
//   sym_start   out  1       data_out is the first sample of a symbol
//   underrun    out  1       sticky: an active symbol ended with no next bit
// -----------------------------------------------------------------------------
module bpsk_symbol_mapper
  import bpsk_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
  parameter int DATA_W          = DEF_DATA_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic signed [DATA_W-1:0] carrier_in,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     out_valid,
  output logic                     sym_start,
  output logic                     underrun
);

  localparam int CNT_W = (SAMPLES_PER_BIT > 2) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  state_t           w_state_next;
  logic             r_cur_bit;
  logic             w_cur_bit_next;
  logic             r_hold_bit;
  logic             r_hold_vld;
  logic             w_hold_vld_next;
  logic             w_hold_load;
  logic             r_underrun;
  logic             w_underrun_next;

  logic             w_boundary;
  logic             w_handshake;

  logic signed [DATA_W-1:0] w_neg;
  logic signed [DATA_W-1:0] w_data_next;
  logic                     w_valid_next;
  logic                     w_start_next;

  assign bit_ready   = ~r_hold_vld;
  assign w_handshake = bit_valid & bit_ready;
  assign w_boundary  = (r_cnt == CNT_LAST);
  assign underrun    = r_underrun;

  // ---------------------------------------------------------------------------
  // State register: phase counter, symbol state, holding register flag,
  // current bit and sticky underrun.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_cnt      <= '0;
      r_state    <= IDLE;
      r_hold_vld <= 1'b0;
      r_cur_bit  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      // The counter free-runs so symbols stay locked to the carrier phase.
      r_cnt      <= w_boundary ? '0 : r_cnt + 1'b1;
      r_state    <= w_state_next;
      r_hold_vld <= w_hold_vld_next;
      r_cur_bit  <= w_cur_bit_next;
      r_underrun <= w_underrun_next;
    end
  end

  // NOTE: the held data bit needs no reset; it is only ever consumed while
  // r_hold_vld is set, and that flag is reset.
  always_ff @(posedge Clk) begin
    if (w_hold_load) begin
      r_hold_bit <= bit_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. At the boundary a held bit wins over a new one; a new
  // bit arriving exactly at the boundary with the hold empty bypasses it.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_cur_bit_next  = r_cur_bit;
    w_hold_vld_next = r_hold_vld;
    w_hold_load     = 1'b0;
    w_underrun_next = r_underrun;

    if (w_boundary) begin
      if (r_hold_vld) begin
        w_cur_bit_next  = r_hold_bit;
        w_hold_vld_next = 1'b0;
        w_state_next    = ACTIVE;
      end else if (w_handshake) begin
        w_cur_bit_next = bit_in;
        w_state_next   = ACTIVE;
      end else begin
        w_state_next = IDLE;
        if (r_state == ACTIVE) begin
          w_underrun_next = 1'b1;
        end
      end
    end else if (w_handshake) begin
      w_hold_load     = 1'b1;
      w_hold_vld_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: modulated sample and flags, registered below.
  // ---------------------------------------------------------------------------
  bpsk_neg_sat #(
    .DATA_W (DATA_W)
  ) u_neg_sat (
    .i_sample (carrier_in),
    .o_sample (w_neg)
  );

  always_comb begin
    w_data_next  = '0;
    w_valid_next = 1'b0;
    w_start_next = 1'b0;
    if (r_state == ACTIVE) begin
      w_data_next  = r_cur_bit ? carrier_in : w_neg;
      w_valid_next = 1'b1;
      w_start_next = (r_cnt == '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      data_out  <= w_data_next;
      out_valid <= w_valid_next;
      sym_start <= w_start_next;
    end
  end

endmodule : bpsk_symbol_mapper

// File: tb/tb_bpsk_symbol_mapper.sv
// -----------------------------------------------------------------------------
// tb_bpsk_symbol_mapper
//   Self-checking bench for bpsk_symbol_mapper. The bench plays the role of
//   the carrier generator: its own phase register is released from reset
//   together with the DUT and indexes a fixed 30-entry carrier table. Each
//   issued bit pushes its 30 expected output samples into a queue; a monitor
//   pops and compares whenever out_valid is high.
// -----------------------------------------------------------------------------
module tb_bpsk_symbol_mapper;
  import bpsk_pkg::*;

  localparam int N  = 30;
  localparam int DW = 8;

  typedef struct {
    int data;
    bit start;
  } exp_t;

  logic                 Clk = 1'b0;
  logic                 Rst_n = 1'b0;
  logic signed [DW-1:0] carrier_in;
  logic                 bit_in = 1'b0;
  logic                 bit_valid = 1'b0;
  logic                 bit_ready;
  logic signed [DW-1:0] data_out;
  logic                 out_valid;
  logic                 sym_start;
  logic                 underrun;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   run_len  = 0;
  int   last_run = 0;
  int   ph       = 0;

  // Hand-picked carrier: index 0 = 16 and the 77 / -77 / -128 corner values
  // sit at phases 1..3, so every bit-0 symbol exercises the saturation case.
  logic signed [DW-1:0] carrier_tab [N] = '{
    16, 77, -77, -128, 0, 127, -1, 1,
    40, 60, 90, 110, 120, 100, 70, 30,
    -10, -50, -85, -110, -125, -127, -115, -95,
    -64, -32, -8, 5, 25, 45
  };

  bpsk_symbol_mapper #(
    .SAMPLES_PER_BIT (N),
    .DATA_W          (DW)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .carrier_in (carrier_in),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .sym_start  (sym_start),
    .underrun   (underrun)
  );

  always #5 Clk = ~Clk;

  // Carrier source phase, reset together with the DUT.
  always @(posedge Clk) begin
    if (!Rst_n) ph <= 0;
    else        ph <= (ph == N-1) ? 0 : ph + 1;
  end
  assign carrier_in = carrier_tab[ph];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int neg_model(input int x);
    int v;
    v = -x;
    if (v > 127) v = 127;
    return v;
  endfunction

  task automatic push_symbol(input bit b, input int n_samples);
    exp_t e;
    for (int k = 0; k < n_samples; k++) begin
      e.data  = b ? int'(carrier_tab[k]) : neg_model(int'(carrier_tab[k]));
      e.start = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int budget;
    budget = 2 * N;
    while (ph != p && budget > 0) begin
      tick();
      budget--;
    end
    check("wait_phase_reached", ph, p);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("queue_drained", exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    Rst_n     = 1'b0;
    bit_valid = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge Clk) begin
    exp_t e;
    if (out_valid) begin
      run_len++;
      check("out_valid_expected", 1, int'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_out", int'(data_out), e.data);
        check("sym_start", int'(sym_start), int'(e.start));
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit stream_bits [4];
    int budget;
    int stray;
    bit accepted;
    stream_bits = '{1'b1, 1'b0, 1'b1, 1'b1};

    // ---- Reset state and 100 idle cycles --------------------------------
    do_reset();
    check("rst_data_out", int'(data_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sym_start", int'(sym_start), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_bit_ready", int'(bit_ready), 1);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_data_out", int'(data_out), 0);
      check("idle_out_valid", int'(out_valid), 0);
      check("idle_bit_ready", int'(bit_ready), 1);
      check("idle_underrun", int'(underrun), 0);
    end

    // ---- Single bit 1 offered at cnt=5 ----------------------------------
    do_reset();
    wait_phase(5);
    push_symbol(1'b1, N);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("held_bit_ready_low", int'(bit_ready), 0);
    wait_phase(N-1);
    check("held_until_boundary", int'(bit_ready), 0);
    tick();
    check("ready_after_boundary", int'(bit_ready), 1);
    wait_drain();
    check("single_symbol_length", last_run, N);
    check("underrun_after_single", int'(underrun), 1);

    // ---- Bit 0: negation and saturation ---------------------------------
    wait_phase(10);
    push_symbol(1'b0, N);
    bit_in    = 1'b0;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    wait_drain();
    check("bit0_symbol_length", last_run, N);

    // ---- Streamed bits 1,0,1,1 with valid held high ---------------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bit_in    = stream_bits[i];
      bit_valid = 1'b1;
      push_symbol(stream_bits[i], N);
      budget   = 100;
      accepted = 1'b0;
      while (!accepted && budget > 0) begin
        accepted = bit_ready;
        tick();
        budget--;
      end
      check("stream_bit_accepted", int'(accepted), 1);
    end
    bit_valid = 1'b0;
    budget = 400;
    while (exp_q.size() > 15 && budget > 0) begin
      tick();
      budget--;
    end
    check("stream_mid_last_symbol", int'(exp_q.size() <= 15), 1);
    check("stream_no_underrun", int'(underrun), 0);
    wait_drain();
    check("stream_run_length", last_run, 4 * N);
    check("stream_underrun_end", int'(underrun), 1);

    // ---- Bypass at the boundary with the hold empty ---------------------
    do_reset();
    wait_phase(N-1);
    check("bypass_ready_before", int'(bit_ready), 1);
    push_symbol(1'b1, N);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("bypass_hold_empty", int'(bit_ready), 1);
    tick();
    check("bypass_sym_start", int'(sym_start), 1);
    wait_drain();
    check("bypass_symbol_length", last_run, N);

    // ---- Reset mid-symbol with a held bit -------------------------------
    do_reset();
    wait_phase(3);
    push_symbol(1'b0, 12);
    bit_in    = 1'b0;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    wait_phase(N-1);
    tick();
    wait_phase(5);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("abort_bit_held", int'(bit_ready), 0);
    wait_phase(12);
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    check("abort_data_out", int'(data_out), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_sym_start", int'(sym_start), 0);
    check("abort_bit_ready", int'(bit_ready), 1);
    check("abort_underrun", int'(underrun), 0);
    tick();
    check("abort_queue_empty", exp_q.size(), 0);
    check("abort_run_length", last_run, 12);
    stray = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (out_valid) stray++;
    end
    check("abort_held_bit_dropped", stray, 0);
    // A fresh symbol must line up with the restarted carrier phase.
    wait_phase(7);
    push_symbol(1'b0, N);
    bit_in    = 1'b0;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    wait_drain();
    check("post_abort_symbol_length", last_run, N);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bpsk_symbol_mapper

// File: doc/bpsk_symbol_mapper.md
Name: bpsk_symbol_mapper

Overview:
Downstream consumer of the free-running signed 8-bit carrier sample stream produced by the sine generator. It accepts one data bit per symbol over a valid/ready handshake. For each symbol it emits SAMPLES_PER_BIT carrier samples, either unchanged (bit 1) or negated (bit 0). Its output is the BPSK baseband-to-DAC sample stream.

Parameters:
SAMPLES_PER_BIT, 30, carrier samples per symbol (one carrier period); legal range 2..255
DATA_W, 8, sample width, two's complement

Ports:
Clk  in  1  system clock; one carrier sample per rising edge
Rst_n  in  1  synchronous, active-low reset
carrier_in  in  DATA_W  signed carrier sample, new value every Clk
bit_in  in  1  data bit to modulate
bit_valid  in  1  bit_in is valid
bit_ready  out  1  mapper can accept a bit this cycle
data_out  out  DATA_W  signed modulated sample (registered)
out_valid  out  1  data_out belongs to an active symbol
sym_start  out  1  pulse: data_out carries the first sample of a symbol
underrun  out  1  sticky: a symbol ended with no next bit available

Behaviour:
- Reset is sampled only on the Clk edge while Rst_n=0. All of the following are cleared: cnt=0, state=IDLE, hold_vld=0, cur_bit=0, data_out=0, out_valid=0, sym_start=0, underrun=0.
- Asserting Rst_n mid-symbol aborts that symbol. The next cycle's output is 0 with out_valid=0, and any held bit is discarded.
- Phase counter cnt counts 0..SAMPLES_PER_BIT-1 and wraps to 0.
  - It runs continuously from reset release, independent of state.
  - A symbol always spans cnt=0..N-1.
  - Alignment to carrier phase is a system-level responsibility and is achieved by releasing both blocks from reset together.
- One-entry holding register (hold_bit, hold_vld):
  - bit_ready = ~hold_vld (combinational from a register).
  - A handshake occurs when bit_valid & bit_ready.
- Boundary edge = the edge at which cnt==N-1. Priority at that edge:
  - If hold_vld=1: cur_bit<=hold_bit, hold_vld<=0, state<=ACTIVE.
  - Else if a handshake occurs this cycle: bypass, cur_bit<=bit_in, state<=ACTIVE, hold not written.
  - Else: state<=IDLE. If state was ACTIVE, underrun<=1 (sticky until reset).
- Non-boundary edge with a handshake: hold_bit<=bit_in, hold_vld<=1.
- States:
  - IDLE: no symbol in progress.
  - ACTIVE: cur_bit is being modulated.
  - Transitions occur only at boundary edges.
  - A bit accepted in IDLE waits for the next boundary, so worst-case wait is N-1 cycles.
- Output register, updated every edge from values sampled at that edge:
  - ACTIVE, cur_bit=1: data_out<=carrier_in.
  - ACTIVE, cur_bit=0: data_out<=neg_sat(carrier_in).
  - IDLE: data_out<=0.
  - out_valid<=(state==ACTIVE).
  - sym_start<=(state==ACTIVE && cnt==0).
  - Latency from carrier_in to data_out is exactly 1 cycle.
- neg_sat: two's complement negation; -(-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1. Negation of 0 yields 0.
- Continuous stream: with bits always available, out_valid stays high with no gaps, and sym_start pulses exactly every N cycles.

Decomposition:
- Package bpsk_pkg holds:
  - the DATA_W and SAMPLES_PER_BIT defaults;
  - the state enum (IDLE, ACTIVE);
  - the constants SAMPLE_MAX and SAMPLE_MIN.
- One sub-module, bpsk_neg_sat: combinational saturating negation, parameter DATA_W. Its only purpose is unit-level reuse by the later QPSK mapper.

Test Plan:
- Reset then idle, bit_valid=0 for 100 cycles -> data_out=0, out_valid=0, bit_ready=1, underrun=0 throughout.
- Bit 1 presented at cnt=5, carrier_in=16 at the cycle where cnt=0 -> handshake at cnt=5, bit_ready=0 until boundary. The cycle after cnt=0: data_out=16, out_valid=1, sym_start=1. out_valid stays high for exactly 30 cycles.
- Bit 0, carrier_in values 77, -77, -128 -> data_out -77, 77, 127 (saturated), each one cycle later.
- Bits 1,0,1,1 streamed with bit_valid held high -> out_valid continuous for 120 cycles, sym_start every 30 cycles, sign flip occurs exactly on the second sym_start, underrun=0 at the end, then underrun=1 after the fourth symbol ends.
- Bit presented only at the cnt=29 edge with hold empty -> bypass, symbol starts immediately (sym_start the cycle after next cnt=0), hold_vld stays 0.
- Rst_n=0 for one edge at cnt=12 of an active symbol with a held bit -> next cycle all outputs 0, bit_ready=1, cnt restarts at 0, held bit never transmitted.
